match_controller: RTL and testbench
===================================

Name: match_controller

Overview:
- Game-flow sequencer for the soccer datapath. Runs once per frame_clk tick.
- Watches the ball position, detects goals, and keeps both scores.
- Drives the ball's centerBall input, plus a freeze signal used by both player blocks.
- Sequences idle, kickoff countdown, live play, goal celebration and game over, and feeds scores and countdown to the text/score overlay.

Parameters:
- GOAL_Y_TOP, 200, top of goal mouth (inclusive), ball-centre Y.
- GOAL_Y_BOT, 280, bottom of goal mouth (inclusive), ball-centre Y.
- GOAL_X_LEFT, 20, left goal line; a goal is scored when BallX-BallS <= GOAL_X_LEFT.
- GOAL_X_RIGHT, 619, right goal line; a goal is scored when BallX+BallS >= GOAL_X_RIGHT.
- KICKOFF_FRAMES, 120, frames held in KICKOFF (1..255).
- CELEBRATE_FRAMES, 90, frames held in GOAL (1..255).
- WIN_SCORE, 5, score that ends the match (1..15).

Ports:
- frame_clk, in, 1, frame-rate clock (vertical sync).
- Reset_n, in, 1, asynchronous active-low reset.
- start, in, 1, level from keycode decode; only a rising edge is used.
- BallX, in, 10, ball centre X.
- BallY, in, 10, ball centre Y.
- BallS, in, 10, ball radius.
- centerBall, out, 1, holds the ball at centre with zero motion.
- freeze, out, 1, player blocks hold position and zero velocity.
- score1, out, 4, player 1 goals.
- score2, out, 4, player 2 goals.
- countdown, out, 8, remaining frames in KICKOFF/GOAL; 0 otherwise.
- last_scorer, out, 2, 00 none, 01 P1, 10 P2.
- winner, out, 2, 00 none, 01 P1, 10 P2.
- game_state, out, 3, IDLE=0, KICKOFF=1, PLAY=2, GOAL=3, GAMEOVER=4.

Behaviour:
- Clocking and outputs:
  - Single clock frame_clk, reset Reset_n asynchronous active-low.
  - All outputs are registered, and all state updates on the posedge of frame_clk.
- Reset values:
  - game_state=IDLE, centerBall=1, freeze=1.
  - score1=score2=0, countdown=0, last_scorer=00, winner=00, start-edge register=0.
- Start edge: start_edge = start & ~start_q, where start_q is registered every cycle.
  - A start held high through reset produces no edge until it is released and pressed again.
- IDLE:
  - centerBall=1, freeze=1.
  - On start_edge, go to KICKOFF: scores=0, last_scorer=00, winner=00, countdown=KICKOFF_FRAMES-1.
- KICKOFF:
  - centerBall=1, freeze=1.
  - If countdown!=0, decrement it.
  - If countdown==0, go to PLAY.
  - Dwell is exactly KICKOFF_FRAMES cycles.
- PLAY:
  - centerBall=0, freeze=0, countdown=0.
  - Left goal: BallY in [GOAL_Y_TOP, GOAL_Y_BOT] and left test true. score2++, last_scorer=10.
  - Right goal: BallY in [GOAL_Y_TOP, GOAL_Y_BOT] and right test true. score1++, last_scorer=01.
  - Left test is computed in 11 bits; if BallX < BallS it is treated as true (no underflow wrap).
  - Right-test sum is computed in 11 bits (no overflow wrap).
  - If both tests are true in the same cycle, left has priority; only score2 increments.
  - On a goal: countdown=CELEBRATE_FRAMES-1, go to GOAL.
  - Scores saturate at 15.
  - Latency: ball sampled at edge N gives centerBall=1 visible after edge N+1 (the goal edge registers the state; outputs follow). The ball therefore takes at most one extra frame of motion.
  - Ball outside the Y window at the goal line: no goal (the ball datapath bounces it).
  - start_edge is ignored.
- GOAL:
  - centerBall=1, freeze=1, countdown decrements.
  - When countdown==0: if score1>=WIN_SCORE or score2>=WIN_SCORE, go to GAMEOVER; else go to KICKOFF with countdown=KICKOFF_FRAMES-1.
  - start_edge is ignored.
- GAMEOVER:
  - centerBall=1, freeze=1, countdown=0.
  - winner is set on entry (01 if score1>=WIN_SCORE, else 10). Scores are held for display.
  - On start_edge, go to KICKOFF with scores, last_scorer and winner cleared.
- Reserved encodings 5–7: go to IDLE next cycle with the reset output values.
- Reset asserted mid-match: immediate return to reset values. No score retention.

Test Plan:
- Reset, then a start pulse at cycle 3: game_state goes 0→1 at edge 4, countdown 119→0 over 120 cycles, state=2 on the following edge, centerBall/freeze fall to 0.
- In PLAY, BallX=24, BallS=4, BallY=240: next edge score2=1, last_scorer=10, state=3, countdown=89; centerBall=1 one edge later.
- In PLAY, BallX=24, BallS=4, BallY=150: no goal, state stays 2.
- In PLAY, BallX=616, BallS=4, BallY=200: score1++. Also drive BallX=2, BallS=4 with a window Y: underflow treated as a left goal, score2++.
- Force score1=4, then a right goal: GOAL for 90 cycles, then state=4, winner=01. start held high gives one transition only; release and re-press start: scores cleared, state=1.
- Deassert Reset_n mid-GOAL (countdown=40, score2=3): all outputs return to reset values asynchronously, before the next clock edge. After release with start still high, no transition until start toggles.

Source files
------------

// File: rtl/match_controller_if.sv
// Game-flow bus between the match controller and the soccer datapath / overlay.
// The slave side is the controller; the master side drives keys and ball position.
interface match_controller_if;
  logic       start;
  logic [9:0] BallX;
  logic [9:0] BallY;
  logic [9:0] BallS;
  logic       centerBall;
  logic       freeze;
  logic [3:0] score1;
  logic [3:0] score2;
  logic [7:0] countdown;
  logic [1:0] last_scorer;
  logic [1:0] winner;
  logic [2:0] game_state;

  modport master (
    output start, BallX, BallY, BallS,
    input  centerBall, freeze, score1, score2, countdown, last_scorer, winner, game_state
  );

  modport slave (
    input  start, BallX, BallY, BallS,
    output centerBall, freeze, score1, score2, countdown, last_scorer, winner, game_state
  );
endinterface

// File: rtl/match_controller.sv
// Per-frame game sequencer: kickoff countdown, live play with goal detection,
// goal celebration and game over. Every output comes straight from a flop.
module match_controller #(
  parameter int unsigned GOAL_Y_TOP       = 200,
  parameter int unsigned GOAL_Y_BOT       = 280,
  parameter int unsigned GOAL_X_LEFT      = 20,
  parameter int unsigned GOAL_X_RIGHT     = 619,
  parameter int unsigned KICKOFF_FRAMES   = 120,
  parameter int unsigned CELEBRATE_FRAMES = 90,
  parameter int unsigned WIN_SCORE        = 5
) (
  input logic               frame_clk,
  input logic               Reset_n,
  match_controller_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StKickoff  = 3'd1,
    StPlay     = 3'd2,
    StGoal     = 3'd3,
    StGameover = 3'd4
  } state_e;

  localparam logic [7:0]  KickoffLoad   = 8'(KICKOFF_FRAMES - 1);
  localparam logic [7:0]  CelebrateLoad = 8'(CELEBRATE_FRAMES - 1);
  localparam logic [9:0]  GoalYTop      = 10'(GOAL_Y_TOP);
  localparam logic [9:0]  GoalYBot      = 10'(GOAL_Y_BOT);
  localparam logic [10:0] GoalXLeft     = 11'(GOAL_X_LEFT);
  localparam logic [10:0] GoalXRight    = 11'(GOAL_X_RIGHT);
  localparam logic [3:0]  WinScore      = 4'(WIN_SCORE);
  localparam logic [1:0]  ScorerNone    = 2'b00;
  localparam logic [1:0]  ScorerP1      = 2'b01;
  localparam logic [1:0]  ScorerP2      = 2'b10;

  state_e     state_q, state_d;
  logic       center_q, center_d;
  logic       freeze_q, freeze_d;
  logic [3:0] score1_q, score1_d;
  logic [3:0] score2_q, score2_d;
  logic [7:0] countdown_q, countdown_d;
  logic [1:0] last_scorer_q, last_scorer_d;
  logic [1:0] winner_q, winner_d;
  logic       start_q;
  logic       armed_q;
  logic       start_edge;

  // armed_q blocks a start that was already held when reset released.
  assign start_edge = bus.start & ~start_q & armed_q;

  logic [10:0] ball_x_w;
  logic [10:0] ball_s_w;
  logic [10:0] left_gap;
  logic [10:0] right_sum;
  logic        in_mouth;
  logic        left_hit;
  logic        right_hit;
  logic        win_reached;

  assign ball_x_w  = {1'b0, bus.BallX};
  assign ball_s_w  = {1'b0, bus.BallS};
  assign left_gap  = ball_x_w - ball_s_w;
  assign right_sum = ball_x_w + ball_s_w;
  assign in_mouth  = (bus.BallY >= GoalYTop) && (bus.BallY <= GoalYBot);
  // A radius wider than X means the ball is already past the left line.
  assign left_hit  = (ball_x_w < ball_s_w) || (left_gap <= GoalXLeft);
  assign right_hit = right_sum >= GoalXRight;
  assign win_reached = (score1_q >= WinScore) || (score2_q >= WinScore);

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hf) ? v : v + 4'd1;
  endfunction

  always_comb begin
    state_d       = state_q;
    center_d      = 1'b1;
    freeze_d      = 1'b1;
    score1_d      = score1_q;
    score2_d      = score2_q;
    countdown_d   = countdown_q;
    last_scorer_d = last_scorer_q;
    winner_d      = winner_q;

    case (state_q)
      StIdle: begin
        if (start_edge) begin
          state_d       = StKickoff;
          score1_d      = 4'd0;
          score2_d      = 4'd0;
          last_scorer_d = ScorerNone;
          winner_d      = ScorerNone;
          countdown_d   = KickoffLoad;
        end
      end

      StKickoff: begin
        if (countdown_q != 8'd0) begin
          countdown_d = countdown_q - 8'd1;
        end else begin
          state_d = StPlay;
        end
      end

      StPlay: begin
        center_d    = 1'b0;
        freeze_d    = 1'b0;
        countdown_d = 8'd0;
        if (in_mouth && left_hit) begin
          score2_d      = sat_inc(score2_q);
          last_scorer_d = ScorerP2;
          countdown_d   = CelebrateLoad;
          state_d       = StGoal;
        end else if (in_mouth && right_hit) begin
          score1_d      = sat_inc(score1_q);
          last_scorer_d = ScorerP1;
          countdown_d   = CelebrateLoad;
          state_d       = StGoal;
        end
      end

      StGoal: begin
        if (countdown_q != 8'd0) begin
          countdown_d = countdown_q - 8'd1;
        end else if (win_reached) begin
          state_d     = StGameover;
          countdown_d = 8'd0;
          winner_d    = (score1_q >= WinScore) ? ScorerP1 : ScorerP2;
        end else begin
          state_d     = StKickoff;
          countdown_d = KickoffLoad;
        end
      end

      StGameover: begin
        countdown_d = 8'd0;
        if (start_edge) begin
          state_d       = StKickoff;
          score1_d      = 4'd0;
          score2_d      = 4'd0;
          last_scorer_d = ScorerNone;
          winner_d      = ScorerNone;
          countdown_d   = KickoffLoad;
        end
      end

      default: begin
        state_d       = StIdle;
        score1_d      = 4'd0;
        score2_d      = 4'd0;
        countdown_d   = 8'd0;
        last_scorer_d = ScorerNone;
        winner_d      = ScorerNone;
      end
    endcase
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= StIdle;
      center_q      <= 1'b1;
      freeze_q      <= 1'b1;
      score1_q      <= 4'd0;
      score2_q      <= 4'd0;
      countdown_q   <= 8'd0;
      last_scorer_q <= ScorerNone;
      winner_q      <= ScorerNone;
      start_q       <= 1'b0;
      armed_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      center_q      <= center_d;
      freeze_q      <= freeze_d;
      score1_q      <= score1_d;
      score2_q      <= score2_d;
      countdown_q   <= countdown_d;
      last_scorer_q <= last_scorer_d;
      winner_q      <= winner_d;
      start_q       <= bus.start;
      armed_q       <= armed_q | ~bus.start;
    end
  end

  assign bus.centerBall  = center_q;
  assign bus.freeze      = freeze_q;
  assign bus.score1      = score1_q;
  assign bus.score2      = score2_q;
  assign bus.countdown   = countdown_q;
  assign bus.last_scorer = last_scorer_q;
  assign bus.winner      = winner_q;
  assign bus.game_state  = state_q;

endmodule

// File: tb/tb_match_controller.sv
// Scoreboard bench for match_controller: a frame-level game model predicts every
// output after each edge; a separate monitor compares on the falling clock edge.
module tb_match_controller;

  localparam int Ko  = 120;
  localparam int Cel = 90;
  localparam int Win = 5;

  typedef struct {
    int st;
    int s1;
    int s2;
    int cd;
    int last;
    int win;
    int center;
    int freeze;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  match_controller_if bus ();

  match_controller dut (
    .frame_clk (clk),
    .Reset_n   (rst_n),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  event sample_ev;

  // Game model state (phase uses the published game_state numbering).
  int m_state, m_s1, m_s2, m_cd, m_last, m_win, m_center, m_freeze;
  bit m_prev_start;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  always @(negedge clk or sample_ev) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("game_state",  int'(bus.game_state),  e.st);
      check("score1",      int'(bus.score1),      e.s1);
      check("score2",      int'(bus.score2),      e.s2);
      check("countdown",   int'(bus.countdown),   e.cd);
      check("last_scorer", int'(bus.last_scorer), e.last);
      check("winner",      int'(bus.winner),      e.win);
      check("centerBall",  int'(bus.centerBall),  e.center);
      check("freeze",      int'(bus.freeze),      e.freeze);
    end
  end

  task automatic push_exp();
    exp_q.push_back('{m_state, m_s1, m_s2, m_cd, m_last, m_win, m_center, m_freeze});
  endtask

  task automatic model_reset();
    m_state = 0; m_s1 = 0; m_s2 = 0; m_cd = 0; m_last = 0; m_win = 0;
    m_center = 1; m_freeze = 1;
    m_prev_start = 1'b1;  // a start held through reset must not count as a press
  endtask

  task automatic new_match();
    m_state = 1; m_s1 = 0; m_s2 = 0; m_last = 0; m_win = 0; m_cd = Ko - 1;
  endtask

  task automatic model_step();
    int  old;
    int  x, y, s;
    bit  press, mouth;
    old   = m_state;
    x     = int'(bus.BallX);
    y     = int'(bus.BallY);
    s     = int'(bus.BallS);
    press = bus.start && !m_prev_start;
    m_prev_start = bus.start;
    mouth = (y >= 200) && (y <= 280);
    case (old)
      0: if (press) new_match();
      1: if (m_cd > 0) m_cd--; else m_state = 2;
      2: begin
        m_cd = 0;
        if (mouth && (x - s <= 20)) begin
          m_s2 = (m_s2 < 15) ? m_s2 + 1 : 15; m_last = 2; m_cd = Cel - 1; m_state = 3;
        end else if (mouth && (x + s >= 619)) begin
          m_s1 = (m_s1 < 15) ? m_s1 + 1 : 15; m_last = 1; m_cd = Cel - 1; m_state = 3;
        end
      end
      3: begin
        if (m_cd > 0) m_cd--;
        else if (m_s1 >= Win || m_s2 >= Win) begin
          m_state = 4; m_cd = 0; m_win = (m_s1 >= Win) ? 1 : 2;
        end else begin
          m_state = 1; m_cd = Ko - 1;
        end
      end
      4: begin
        m_cd = 0;
        if (press) new_match();
      end
      default: model_reset();
    endcase
    m_center = (old != 2) ? 1 : 0;
    m_freeze = m_center;
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    model_step();
    push_exp();
    #1;
  endtask

  task automatic set_ball(input int x, input int y, input int s);
    bus.BallX = 10'(x);
    bus.BallY = 10'(y);
    bus.BallS = 10'(s);
  endtask

  // Assert reset in the low clock phase and check outputs before the next rising edge.
  task automatic do_reset(input int hold);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    push_exp();
    #2;
    ->sample_ev;
    repeat (hold) begin
      @(posedge clk);
      cyc++;
      push_exp();
      #1;
    end
    rst_n = 1'b1;
  endtask

  task automatic run_until(input int target, input int budget);
    int n = 0;
    while (m_state != target && n < budget) begin
      cycle();
      n++;
    end
    if (m_state != target) begin
      errors++;
      $display("FAIL run_until: state %0d, expected %0d within %0d cycles", m_state, target,
               budget);
    end
  endtask

  task automatic shot(input int x, input int y, input int s);
    set_ball(x, y, s);
    cycle();
    set_ball(320, 240, 8);
    cycle();
  endtask

  initial begin
    bus.start = 1'b0;
    set_ball(320, 240, 8);
    model_reset();
    do_reset(1);

    cycle(); cycle();
    bus.start = 1'b1; cycle();
    bus.start = 1'b0; cycle();
    run_until(2, 200);
    cycle();

    shot(24, 240, 4);               // left goal
    run_until(2, 400); cycle();
    shot(24, 150, 4);               // outside mouth: no goal
    cycle();
    shot(616, 200, 4);              // right goal at top edge of mouth
    run_until(2, 400); cycle();
    shot(2, 250, 4);                // radius wider than X: left goal
    run_until(2, 400); cycle();

    while (m_s1 < 4) begin
      shot(619, 280, 0);
      run_until(2, 400);
    end
    bus.start = 1'b1;               // held high into game over
    shot(610, 230, 9);
    run_until(4, 400);
    repeat (5) cycle();
    bus.start = 1'b0; cycle();
    bus.start = 1'b1; cycle();
    bus.start = 1'b0; cycle(); cycle();

    // Mid-celebration reset with start held through it.
    run_until(2, 400);
    repeat (3) begin
      shot(20, 200, 0);
      if (m_s2 < 3) run_until(2, 400);
    end
    while (m_state == 3 && m_cd != 40) cycle();
    bus.start = 1'b1;
    do_reset(2);
    repeat (4) cycle();
    bus.start = 1'b0; cycle();
    bus.start = 1'b1; cycle();
    bus.start = 1'b0; cycle();

    // Randomized play, including inputs while not in PLAY.
    for (int i = 0; i < 4000; i++) begin
      bus.start = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 11))
        0: set_ball($urandom_range(0, 40), $urandom_range(150, 330), $urandom_range(0, 10));
        1: set_ball($urandom_range(600, 639), $urandom_range(150, 330), $urandom_range(0, 10));
        2: set_ball($urandom_range(900, 1023), $urandom_range(190, 290),
                    $urandom_range(900, 1023));
        default: set_ball($urandom_range(60, 580), $urandom_range(0, 479), $urandom_range(1, 8));
      endcase
      cycle();
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
